// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - opcodes, FSM encoding and predecode helper for the IF stage
package instruction_fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } ifu_state_t;

    // True for the two unconditional jumps resolved locally in fetch
    function automatic logic is_jump_op(input logic [31:0] instr);
        return (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// rtl/instruction_fetch_unit_if_id_reg.sv - IF/ID pipeline register with load/hold/clear
module if_id_reg
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid
);

    // Clear only drops valid so decode ignores stale fields; load captures a new word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instr    <= 32'd0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus1 <= 32'd0;
            if_id_valid    <= 1'b0;
        end else if (clear) begin
            if_id_valid    <= 1'b0;
        end else if (load) begin
            if_id_instr    <= instr;
            if_id_pc       <= pc;
            if_id_pc_plus1 <= pc + 32'd1;
            if_id_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC, J/JAL predecode, halt on range; optional IFU_PERF_CNT_EN counters
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        halted
);

    ifu_state_t  state;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic [31:0] next_pc;
    logic        load;
    logic        clear;
    logic        stall_edge;

    assign imem_addr = pc;
    assign pc_plus1  = pc + 32'd1;
    // Jumps keep the top six bits of the sequential PC and take the 26-bit field
    assign next_pc   = is_jump_op(imem_instr) ? {pc_plus1[31:26], imem_instr[25:0]} : pc_plus1;

    // IF/ID controls derived from state and the redirect > range > flush > stall priority
    always_comb begin
        load  = 1'b0;
        clear = 1'b0;
        case (state)
            S_RUN: begin
                if (redirect_valid || (pc > PC_LIMIT) || flush) begin
                    clear = 1'b1;
                end else if (!stall) begin
                    load = 1'b1;
                end
            end
            S_HALT:  clear = 1'b1;
            default: ;
        endcase
    end

    assign stall_edge = (state == S_RUN) && stall && !redirect_valid && !flush;

    // Fetch FSM: owns PC and the registered halted flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_BOOT;
            pc     <= PC_RESET;
            halted <= 1'b0;
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end else if (pc > PC_LIMIT) begin
                        // an out-of-range redirect landed last edge
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (!flush && !stall) begin
                        if (next_pc > PC_LIMIT) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                S_HALT: begin
                    if (redirect_valid && (redirect_target <= PC_LIMIT)) begin
                        pc     <= redirect_target;
                        halted <= 1'b0;
                        state  <= S_RUN;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .load           (load),
        .clear          (clear),
        .instr          (imem_instr),
        .pc             (pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid)
    );

`ifdef IFU_PERF_CNT_EN
    // Fetch counter counts real captures; stall counter saturates
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall_edge && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    logic unused_stall_edge;
    assign unused_stall_edge = stall_edge;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed and randomized check of instruction_fetch_unit against a reference model
module tb_instruction_fetch_unit;

    localparam logic [31:0] LIMIT = 32'd255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: architectural view of fetch
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc1;
    bit          m_valid, m_boot, m_halt;

    instruction_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .stall           (stall),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus1  (if_id_pc_plus1),
        .if_id_valid     (if_id_valid),
`ifdef IFU_PERF_CNT_EN
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
`endif
        .halted          (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return (a <= 32'd255) ? mem[a[7:0]] : 32'h0;
    endfunction

    assign imem_instr = mem_read(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_instr = 0; m_ipc = 0; m_ipc1 = 0;
        m_valid = 0; m_boot = 1; m_halt = 0;
    endtask

    task automatic model_edge(input bit st, input bit fl, input bit rv, input logic [31:0] rt);
        logic [31:0] ins;
        logic [31:0] nxt;
        ins = mem_read(m_pc);
        if (m_boot) begin
            m_boot = 0;
        end else if (m_halt) begin
            m_valid = 0;
            if (rv && rt <= LIMIT) begin m_pc = rt; m_halt = 0; end
        end else if (rv) begin
            m_pc = rt; m_valid = 0;
        end else if (m_pc > LIMIT) begin
            m_halt = 1; m_valid = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (!st) begin
            m_instr = ins; m_ipc = m_pc; m_ipc1 = m_pc + 1; m_valid = 1;
            if (ins[31:26] == 6'd2 || ins[31:26] == 6'd3)
                nxt = {m_ipc1[31:26], ins[25:0]};
            else
                nxt = m_pc + 1;
            if (nxt > LIMIT) m_halt = 1;
            else m_pc = nxt;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".addr"},  imem_addr, m_pc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({tag, ".halt"},  {31'd0, halted}, {31'd0, m_halt});
        if (m_valid) begin
            check({tag, ".instr"}, if_id_instr, m_instr);
            check({tag, ".pc"},    if_id_pc, m_ipc);
            check({tag, ".pc1"},   if_id_pc_plus1, m_ipc1);
        end
    endtask

    task automatic step(input string tag, input bit st, input bit fl, input bit rv, input logic [31:0] rt);
        stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
        model_edge(st, fl, rv, rt);
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 0; flush = 0; redirect_valid = 0; redirect_target = 0;
        #2;
        model_reset();
        check("rst.addr",  imem_addr, 32'd0);
        check("rst.instr", if_id_instr, 32'd0);
        check("rst.pc",    if_id_pc, 32'd0);
        check("rst.pc1",   if_id_pc_plus1, 32'd0);
        check("rst.valid", {31'd0, if_id_valid}, 32'd0);
        check("rst.halt",  {31'd0, halted}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_default_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h02B4B020 + i;
        mem[26] = 32'h08000074;
        mem[27] = 32'h0C000074;
    endtask

    initial begin
        bit reached;
        load_default_mem();
        do_reset();

        // boot cycle then sequential fetch
        step("boot", 0, 0, 0, 0);
        check("boot.valid", {31'd0, if_id_valid}, 32'd0);
        step("f0", 0, 0, 0, 0);
        check("f0.instr", if_id_instr, 32'h02B4B020);
        check("f0.pc",    if_id_pc, 32'd0);
        check("f0.valid", {31'd0, if_id_valid}, 32'd1);
        check("f0.addr",  imem_addr, 32'd1);
        step("f1", 0, 0, 0, 0);
        check("f1.addr", imem_addr, 32'd2);
        step("f2", 0, 0, 0, 0);
        check("f2.addr", imem_addr, 32'd3);
        step("f3", 0, 0, 0, 0);
        step("f4", 0, 0, 0, 0);
        check("pre_stall.addr", imem_addr, 32'd5);

        // stall for three cycles at PC=5
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 0, 0, 0);
            check("stall.addr",  imem_addr, 32'd5);
            check("stall.instr", if_id_instr, 32'h02B4B024);
        end
        step("resume", 0, 0, 0, 0);
        check("resume.instr", if_id_instr, 32'h02B4B025);

        // run to the J at 26
        reached = 0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (imem_addr == 32'd26) reached = 1;
            else step("run", 0, 0, 0, 0);
        end
        check("reach_pc26", {31'd0, reached}, 32'd1);
        step("j", 0, 0, 0, 0);
        check("j.instr", if_id_instr, 32'h08000074);
        check("j.pc",    if_id_pc, 32'd26);
        check("j.pc1",   if_id_pc_plus1, 32'd27);
        check("j.addr",  imem_addr, 32'd116);
        step("to27", 0, 0, 1, 32'd27);
        step("jal", 0, 0, 0, 0);
        check("jal.pc1",  if_id_pc_plus1, 32'd28);
        check("jal.addr", imem_addr, 32'd116);

        // redirect beats stall and flush
        step("redir", 1, 1, 1, 32'd31);
        check("redir.addr",  imem_addr, 32'd31);
        check("redir.valid", {31'd0, if_id_valid}, 32'd0);
        step("w31", 0, 0, 0, 0);
        check("w31.instr", if_id_instr, 32'h02B4B03F);
        check("w31.valid", {31'd0, if_id_valid}, 32'd1);

        // flush with stall: flush wins
        step("flst", 1, 1, 0, 0);
        check("flst.addr",  imem_addr, 32'd32);
        check("flst.valid", {31'd0, if_id_valid}, 32'd0);

        // top of range halts after capturing word 255
        step("to255", 0, 0, 1, 32'd255);
        step("w255", 0, 0, 0, 0);
        check("w255.instr",  if_id_instr, 32'h02B4B11F);
        check("w255.halted", {31'd0, halted}, 32'd1);
        step("halt", 0, 0, 0, 0);
        check("halt.valid", {31'd0, if_id_valid}, 32'd0);
        step("halt_oor", 0, 0, 1, 32'd300);
        check("halt_oor.halted", {31'd0, halted}, 32'd1);
        step("unhalt", 0, 0, 1, 32'd0);
        check("unhalt.halted", {31'd0, halted}, 32'd0);
        check("unhalt.addr",   imem_addr, 32'd0);
        step("w0", 0, 0, 0, 0);
        check("w0.instr", if_id_instr, 32'h02B4B020);

        // out-of-range redirect while running: halt next edge with no capture
        step("oor", 0, 0, 1, 32'd400);
        check("oor.addr", imem_addr, 32'd400);
        step("oor2", 0, 0, 0, 0);
        check("oor2.halted", {31'd0, halted}, 32'd1);
        step("oor3", 0, 0, 1, 32'd10);

`ifdef IFU_PERF_CNT_EN
        do_reset();
        check("perf.rst_fetch", fetch_count, 32'd0);
        step("pboot", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("pf", 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("ps", 1, 0, 0, 0);
        check("perf.fetch", fetch_count, 32'd10);
        check("perf.stall", stall_count, 32'd3);
        do_reset();
        check("perf.zero_fetch", fetch_count, 32'd0);
        check("perf.zero_stall", stall_count, 32'd0);
        step("pboot2", 0, 0, 0, 0);
`endif

        // randomized program and control traffic
        for (int i = 0; i < 256; i++) begin
            logic [31:0] r;
            r = $urandom;
            if ($urandom_range(0, 5) == 0)
                r = {5'b00001, 1'($urandom_range(0, 1)), 26'($urandom_range(0, 280))};
            else if (r[31:26] == 6'd2 || r[31:26] == 6'd3)
                r[31:26] = 6'd0;
            mem[i] = r;
        end
        do_reset();
        step("rboot", 0, 0, 0, 0);
        for (int c = 0; c < 800; c++) begin
            bit st, fl, rv;
            logic [31:0] rt;
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            rv = ($urandom_range(0, 99) < 10);
            rt = $urandom_range(0, 270);
            if (c == 400) begin
                do_reset();
                step("rboot2", 0, 0, 0, 0);
            end else begin
                step("rand", st, fl, rv, rt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
